mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage that sits directly downstream of the EX/MEM pipeline register and consumes its `mem_*` outputs. It turns load/store instructions into transactions on an SRAM-like data bus (req/addr_ok/data_ok), holds the pipeline with `data_stall` until each transaction completes, and produces the sign- or zero-extended load result for write-back. While a transaction is pending, `data_stall` freezes the EX/MEM register, so the instruction and its fields stay stable at this block's inputs.

## Interface
Parameters: none. Opcodes are the `EXE_LB_OP`, `EXE_LBU_OP`, `EXE_LH_OP`, `EXE_LHU_OP`, `EXE_LW_OP`, `EXE_SB_OP`, `EXE_SH_OP` and `EXE_SW_OP` macros from `defines.vh`.
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `exception`  in  1  pipeline flush, same meaning as at EX/MEM
- `mem_aluop`  in  `ALUOP_BUS`  operation
- `mem_exception_type`  in  `EXCEP_TYPE_BUS`  non-zero suppresses the access
- `mem_mem_to_reg`  in  1  instruction is a load
- `mem_ram_write_enable`  in  1  instruction is a store
- `mem_alu_data`  in  32  effective address, or ALU result for non-memory instructions
- `mem_ram_write_data`  in  32  store data (rt)
- `data_req`  out  1  bus request
- `data_wr`  out  1  1 = write
- `data_size`  out  2  0 = byte, 1 = half, 2 = word
- `data_addr`  out  32  byte address
- `data_wdata`  out  32  write data
- `data_addr_ok`  in  1  request accepted
- `data_data_ok`  in  1  read data valid, or write complete
- `data_rdata`  in  32  read data
- `data_stall`  out  1  hold EX/MEM and everything upstream
- `mem_result`  out  32  write-back value
- `addr_exc_load`  out  1  AdEL
- `addr_exc_store`  out  1  AdES
- `bad_vaddr`  out  32  faulting address

## Operation
- A valid access is `(mem_mem_to_reg | mem_ram_write_enable) & mem_exception_type == 0 & !exception & !misaligned`.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN. All are registered; reset state is IDLE.
  - IDLE, valid access present: `data_req` = 1. If `data_addr_ok` is high → WAIT; otherwise → REQ.
  - REQ: `data_req` = 1 and the request fields are held constant. `data_addr_ok` → WAIT. A flush does not drop the request; the block still goes to WAIT, then DRAIN.
  - WAIT: when `data_data_ok` is high, capture `data_rdata` into `rdata_q` and go to DONE. If a flush occurs in WAIT or REQ, go to DRAIN instead of DONE.
  - DONE: one cycle with `data_stall` = 0 so the pipeline advances, then → IDLE unconditionally.
  - DRAIN: wait for `data_data_ok`, discard the data, → IDLE.
- `data_stall` = valid access & state ∉ {DONE}. In DRAIN it is asserted whenever a load or store is present at the inputs.
- Request fields:
  - `data_addr` = `mem_alu_data`.
  - `data_wr` = `mem_ram_write_enable`.
  - `data_size` comes from the opcode.
  - `data_wdata` replicates the store operand: SB → {4{rt[7:0]}}, SH → {2{rt[15:0]}}, SW → rt.
- Load result: the byte or half is selected from `rdata_q` by `addr[1:0]` (little-endian). LB and LH sign-extend; LBU and LHU zero-extend.
- `mem_result` is the extended load data for a load in DONE, and `mem_alu_data` in every other case.

## Timing
- Reset state: FSM in IDLE, `rdata_q` = 0. While `rst` is low: `data_req` = 0, `data_stall` = 0, `addr_exc_*` = 0, `bad_vaddr` = 0.
- Minimum latency is 2 stall cycles. Example: `addr_ok` in the IDLE cycle, `data_ok` in the next cycle; DONE follows and the pipeline advances.
- `addr_ok` and `data_ok` in the same cycle is not legal on the bus; the block only ever samples `data_ok` in WAIT or DRAIN.
- A non-memory instruction never stalls and never issues a request.

## Configuration
- `MEM_ADDR_EXC_EN` defined:
  - Misaligned means LH, LHU or SH with `addr[0]` = 1, or LW or SW with `addr[1:0]` ≠ 0.
  - A misaligned access is not issued, `data_stall` stays 0, and `addr_exc_load` or `addr_exc_store` is raised combinationally.
  - `bad_vaddr` = `mem_alu_data` while either exception flag is high.
- `MEM_ADDR_EXC_EN` undefined:
  - misaligned is tied to 0;
  - `addr_exc_*` = 0 and `bad_vaddr` = 0;
  - the access is issued with the raw address.

## Test plan
- LW at 0x1000, `addr_ok` immediate, `data_ok` one cycle later with rdata 0x8899AABB → 2 stall cycles, `mem_result` = 0x8899AABB in DONE.
- LB at 0x1003, then LBU at 0x1003, rdata 0x80112233 → `mem_result` 0xFFFFFF80, then 0x00000080.
- SH at 0x2002, rt 0x1234ABCD, `addr_ok` delayed 3 cycles → `data_req` held for 4 cycles with `data_size` 1 and `data_wdata` 0xABCDABCD; `data_stall` stays high until DONE.
- Flush while in WAIT → DRAIN; the next LW is stalled until the old `data_ok` arrives; the stale rdata never appears on `mem_result`.
- With `MEM_ADDR_EXC_EN`, LW at 0x1002 → `addr_exc_load` = 1, `bad_vaddr` = 0x1002, no `data_req`, `data_stall` = 0.
- `rst` asserted low while in WAIT → outputs return to their reset values immediately; the FSM is in IDLE after release.

Source files
------------

// File: rtl/mem_access_if.sv
// SRAM-like data bus between the memory-access stage (master) and the data memory (slave).
interface mem_access_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores on the SRAM-like bus, stalls until done, extends load data.
// Optional feature: define MEM_ADDR_EXC_EN to trap misaligned halfword/word accesses (AdEL/AdES).
`ifndef ALUOP_BUS
`define ALUOP_BUS      7:0
`endif
`ifndef EXCEP_TYPE_BUS
`define EXCEP_TYPE_BUS 31:0
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LH_OP  8'b11100001
`define EXE_LW_OP  8'b11100011
`define EXE_LBU_OP 8'b11100100
`define EXE_LHU_OP 8'b11100101
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`endif

module mem_access (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exception,
  input  logic [`ALUOP_BUS]      mem_aluop,
  input  logic [`EXCEP_TYPE_BUS] mem_exception_type,
  input  logic                   mem_mem_to_reg,
  input  logic                   mem_ram_write_enable,
  input  logic [31:0]            mem_alu_data,
  input  logic [31:0]            mem_ram_write_data,
  mem_access_if.master           data,
  output logic                   data_stall,
  output logic [31:0]            mem_result,
  output logic                   addr_exc_load,
  output logic                   addr_exc_store,
  output logic [31:0]            bad_vaddr
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t      state;
  logic        flush_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        wr_q;

  logic        is_mem;
  logic        valid;
  logic        misaligned;
  logic [1:0]  cur_size;
  logic [31:0] cur_wdata;

  function automatic logic [1:0] op_size(input logic [`ALUOP_BUS] op);
    case (op)
      `EXE_LB_OP, `EXE_LBU_OP, `EXE_SB_OP: return 2'd0;
      `EXE_LH_OP, `EXE_LHU_OP, `EXE_SH_OP: return 2'd1;
      default:                             return 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [`ALUOP_BUS] op, input logic [31:0] rt);
    case (op)
      `EXE_SB_OP: return {4{rt[7:0]}};
      `EXE_SH_OP: return {2{rt[15:0]}};
      default:    return rt;
    endcase
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_ext(input logic [`ALUOP_BUS] op, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      `EXE_LB_OP:  return {{24{b[7]}}, b};
      `EXE_LBU_OP: return {24'd0, b};
      `EXE_LH_OP:  return {{16{h[15]}}, h};
      `EXE_LHU_OP: return {16'd0, h};
      default:     return w;
    endcase
  endfunction

`ifdef MEM_ADDR_EXC_EN
  always_comb begin
    misaligned = 1'b0;
    case (mem_aluop)
      `EXE_LH_OP, `EXE_LHU_OP, `EXE_SH_OP: misaligned = mem_alu_data[0];
      `EXE_LW_OP, `EXE_SW_OP:              misaligned = |mem_alu_data[1:0];
      default:                             misaligned = 1'b0;
    endcase
  end
  assign addr_exc_load  = rst & mem_mem_to_reg & misaligned;
  assign addr_exc_store = rst & mem_ram_write_enable & misaligned;
  assign bad_vaddr      = (addr_exc_load | addr_exc_store) ? mem_alu_data : 32'd0;
`else
  assign misaligned     = 1'b0;
  assign addr_exc_load  = 1'b0;
  assign addr_exc_store = 1'b0;
  assign bad_vaddr      = 32'd0;
`endif

  assign is_mem    = mem_mem_to_reg | mem_ram_write_enable;
  assign valid     = is_mem & (mem_exception_type == '0) & ~exception & ~misaligned;
  assign cur_size  = op_size(mem_aluop);
  assign cur_wdata = store_data(mem_aluop, mem_ram_write_data);

  // Request fields come live from the inputs in IDLE and from the captured copy while retrying.
  always_comb begin
    data.req   = 1'b0;
    data.wr    = mem_ram_write_enable;
    data.size  = cur_size;
    data.addr  = mem_alu_data;
    data.wdata = cur_wdata;
    if (state == REQ) begin
      data.req   = rst;
      data.wr    = wr_q;
      data.size  = size_q;
      data.addr  = addr_q;
      data.wdata = wdata_q;
    end else if (state == IDLE) begin
      data.req   = rst & valid;
    end
  end

  always_comb begin
    case (state)
      DONE:    data_stall = 1'b0;
      DRAIN:   data_stall = rst & is_mem;
      default: data_stall = rst & valid;
    endcase
  end

  assign mem_result = (state == DONE && mem_mem_to_reg) ? load_ext(mem_aluop, mem_alu_data[1:0], rdata_q)
                                                        : mem_alu_data;

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      addr_q  <= mem_alu_data;
      wdata_q <= cur_wdata;
      size_q  <= cur_size;
      wr_q    <= mem_ram_write_enable;
    end
  end

  // A flush seen in REQ is remembered so the matching data_ok is drained, not delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      flush_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          flush_q <= 1'b0;
          if (valid) state <= data.addr_ok ? WAIT : REQ;
        end
        REQ: begin
          if (exception)    flush_q <= 1'b1;
          if (data.addr_ok) state   <= WAIT;
        end
        WAIT: begin
          if (data.data_ok) begin
            flush_q <= 1'b0;
            if (flush_q | exception) begin
              state <= IDLE;
            end else begin
              rdata_q <= data.rdata;
              state   <= DONE;
            end
          end else if (flush_q | exception) begin
            state <= DRAIN;
          end
        end
        DONE:  state <= IDLE;
        DRAIN: begin
          if (data.data_ok) begin
            flush_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table vectors, random transactions vs. a lane/extension model,
// and hand-written flush, reset and misalignment sequences.
`ifndef ALUOP_BUS
`define ALUOP_BUS      7:0
`endif
`ifndef EXCEP_TYPE_BUS
`define EXCEP_TYPE_BUS 31:0
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LH_OP  8'b11100001
`define EXE_LW_OP  8'b11100011
`define EXE_LBU_OP 8'b11100100
`define EXE_LHU_OP 8'b11100101
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`endif

module tb_mem_access;
  logic                   clk = 1'b0;
  logic                   rst;
  logic                   exception;
  logic [`ALUOP_BUS]      aluop;
  logic [`EXCEP_TYPE_BUS] exc_type;
  logic                   m2r;
  logic                   we;
  logic [31:0]            alu_data;
  logic [31:0]            rt;
  logic                   stall;
  logic [31:0]            result;
  logic                   exc_l;
  logic                   exc_s;
  logic [31:0]            bva;

  mem_access_if bus ();

  mem_access dut (
    .clk                  (clk),
    .rst                  (rst),
    .exception            (exception),
    .mem_aluop            (aluop),
    .mem_exception_type   (exc_type),
    .mem_mem_to_reg       (m2r),
    .mem_ram_write_enable (we),
    .mem_alu_data         (alu_data),
    .mem_ram_write_data   (rt),
    .data                 (bus),
    .data_stall           (stall),
    .mem_result           (result),
    .addr_exc_load        (exc_l),
    .addr_exc_store       (exc_s),
    .bad_vaddr            (bva)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic op_is_load(input logic [7:0] op);
    return op == `EXE_LB_OP || op == `EXE_LBU_OP || op == `EXE_LH_OP ||
           op == `EXE_LHU_OP || op == `EXE_LW_OP;
  endfunction

  function automatic logic [1:0] model_size(input logic [7:0] op);
    if (op == `EXE_LB_OP || op == `EXE_LBU_OP || op == `EXE_SB_OP) return 2'd0;
    if (op == `EXE_LH_OP || op == `EXE_LHU_OP || op == `EXE_SH_OP) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] v);
    logic [31:0] b;
    logic [31:0] h;
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    if (op == `EXE_SB_OP) return b * 32'h01010101;
    if (op == `EXE_SH_OP) return h * 32'h00010001;
    return v;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] b;
    logic [31:0] h;
    sh = rd >> (8 * addr[1:0]);
    b  = sh & 32'hFF;
    h  = sh & 32'hFFFF;
    case (op)
      `EXE_LB_OP:  return (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b;
      `EXE_LBU_OP: return b;
      `EXE_LH_OP:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      `EXE_LHU_OP: return h;
      default:     return rd;
    endcase
  endfunction

  task automatic drive_instr(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] v);
    aluop    = op;
    m2r      = op_is_load(op);
    we       = !op_is_load(op);
    alu_data = addr;
    rt       = v;
  endtask

  task automatic drive_nop();
    aluop    = 8'h21;
    m2r      = 1'b0;
    we       = 1'b0;
    alu_data = $urandom;
    rt       = $urandom;
  endtask

  // Starts at a negedge with the block idle; acts as the bus slave with the given latencies.
  task automatic run_txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] v, input logic [31:0] rd, input int alat, input int dlat,
                         input logic [31:0] exp_res, input logic [1:0] exp_sz, input logic [31:0] exp_wd);
    int   req_cnt;
    int   stalls;
    int   acc;
    logic done;
    req_cnt = 0;
    stalls  = 0;
    acc     = -1;
    done    = 1'b0;
    drive_instr(op, addr, v);
    for (int c = 0; c < 60 && !done; c++) begin
      bus.addr_ok = 1'b0;
      bus.data_ok = 1'b0;
      bus.rdata   = $urandom;
      #1;
      if (bus.req) begin
        req_cnt++;
        check({tag, " addr"}, bus.addr, addr);
        check({tag, " size"}, {30'd0, bus.size}, {30'd0, exp_sz});
        check({tag, " wr"}, {31'd0, bus.wr}, {31'd0, !op_is_load(op)});
        if (!op_is_load(op)) check({tag, " wdata"}, bus.wdata, exp_wd);
        if (req_cnt == alat + 1) begin
          bus.addr_ok = 1'b1;
          acc = c;
        end
      end
      if (acc >= 0 && c == acc + dlat) begin
        bus.data_ok = 1'b1;
        bus.rdata   = rd;
      end
      if (!stall) begin
        done = 1'b1;
        check({tag, " result"}, result, exp_res);
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    bus.addr_ok = 1'b0;
    bus.data_ok = 1'b0;
    check({tag, " completed"}, {31'd0, done}, 32'd1);
    check({tag, " stall cycles"}, stalls, alat + 1 + dlat);
    check({tag, " req cycles"}, req_cnt, alat + 1);
    drive_nop();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          alat;
    int          dlat;
    logic [31:0] exp_res;
    logic [1:0]  exp_sz;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[9];
  logic [7:0] ops[8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{`EXE_LW_OP,  32'h1000, 32'h0,        32'h8899AABB, 0, 1, 32'h8899AABB, 2'd2, 32'h0};
    vecs[1] = '{`EXE_LB_OP,  32'h1003, 32'h0,        32'h80112233, 0, 1, 32'hFFFFFF80, 2'd0, 32'h0};
    vecs[2] = '{`EXE_LBU_OP, 32'h1003, 32'h0,        32'h80112233, 0, 1, 32'h00000080, 2'd0, 32'h0};
    vecs[3] = '{`EXE_LH_OP,  32'h1002, 32'h0,        32'h80112233, 1, 1, 32'hFFFF8011, 2'd1, 32'h0};
    vecs[4] = '{`EXE_LHU_OP, 32'h1000, 32'h0,        32'h80118233, 0, 2, 32'h00008233, 2'd1, 32'h0};
    vecs[5] = '{`EXE_LB_OP,  32'h1001, 32'h0,        32'h80112233, 2, 1, 32'h00000022, 2'd0, 32'h0};
    vecs[6] = '{`EXE_SH_OP,  32'h2002, 32'h1234ABCD, 32'h0,        3, 1, 32'h00002002, 2'd1, 32'hABCDABCD};
    vecs[7] = '{`EXE_SB_OP,  32'h2001, 32'h1234ABCD, 32'h0,        0, 1, 32'h00002001, 2'd0, 32'hCDCDCDCD};
    vecs[8] = '{`EXE_SW_OP,  32'h2004, 32'h1234ABCD, 32'h0,        1, 2, 32'h00002004, 2'd2, 32'h1234ABCD};
    ops = '{`EXE_LB_OP, `EXE_LBU_OP, `EXE_LH_OP, `EXE_LHU_OP, `EXE_LW_OP,
            `EXE_SB_OP, `EXE_SH_OP, `EXE_SW_OP};

    rst         = 1'b0;
    exception   = 1'b0;
    exc_type    = '0;
    bus.addr_ok = 1'b0;
    bus.data_ok = 1'b0;
    bus.rdata   = 32'h0;
    drive_instr(`EXE_LW_OP, 32'h1001, 32'h0);
    #1;
    check("reset req", {31'd0, bus.req}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset exc_load", {31'd0, exc_l}, 32'd0);
    check("reset bad_vaddr", bva, 32'd0);
    repeat (2) @(negedge clk);
    drive_nop();
    rst = 1'b1;
    @(negedge clk);

    // Non-memory instruction and a suppressed (excepting) load.
    aluop = 8'h21; m2r = 1'b0; we = 1'b0; alu_data = 32'h55AA0011;
    #1;
    check("nonmem stall", {31'd0, stall}, 32'd0);
    check("nonmem req", {31'd0, bus.req}, 32'd0);
    check("nonmem result", result, 32'h55AA0011);
    @(negedge clk);
    drive_instr(`EXE_LW_OP, 32'h1000, 32'h0);
    exc_type = 32'h1;
    #1;
    check("exctype req", {31'd0, bus.req}, 32'd0);
    check("exctype stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    exc_type = '0;
    drive_nop();
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].rdata,
              vecs[i].alat, vecs[i].dlat, vecs[i].exp_res, vecs[i].exp_sz, vecs[i].exp_wd);

    for (int i = 0; i < 40; i++) begin
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] v;
      logic [31:0] rd;
      logic [31:0] er;
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      if (model_size(op) == 2'd1) a = a & ~32'h1;
      if (model_size(op) == 2'd2) a = a & ~32'h3;
      v  = $urandom;
      rd = $urandom;
      er = op_is_load(op) ? model_load(op, a, rd) : a;
      run_txn($sformatf("rnd%0d", i), op, a, v, rd, $urandom_range(0, 3), $urandom_range(1, 3),
              er, model_size(op), model_wdata(op, v));
    end

    // Flush in WAIT: old data_ok is drained, the next load waits for it.
    drive_instr(`EXE_LW_OP, 32'h1000, 32'h0);
    #1;
    check("flush issue req", {31'd0, bus.req}, 32'd1);
    bus.addr_ok = 1'b1;
    @(negedge clk);
    bus.addr_ok = 1'b0;
    exception   = 1'b1;
    #1;
    check("flush cycle req", {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    exception = 1'b0;
    drive_instr(`EXE_LW_OP, 32'h3000, 32'h0);
    #1;
    check("drain stall", {31'd0, stall}, 32'd1);
    check("drain req", {31'd0, bus.req}, 32'd0);
    check("drain result", result, 32'h3000);
    bus.data_ok = 1'b1;
    bus.rdata   = 32'hDEADBEEF;
    @(negedge clk);
    bus.data_ok = 1'b0;
    #1;
    check("post-drain req", {31'd0, bus.req}, 32'd1);
    check("post-drain addr", bus.addr, 32'h3000);
    check("post-drain result", result, 32'h3000);
    bus.addr_ok = 1'b1;
    @(negedge clk);
    bus.addr_ok = 1'b0;
    #1;
    check("post-drain wait stall", {31'd0, stall}, 32'd1);
    check("post-drain wait result", result, 32'h3000);
    bus.data_ok = 1'b1;
    bus.rdata   = 32'h11223344;
    @(negedge clk);
    bus.data_ok = 1'b0;
    #1;
    check("post-drain done stall", {31'd0, stall}, 32'd0);
    check("post-drain done result", result, 32'h11223344);
    @(negedge clk);
    drive_nop();
    @(negedge clk);

    // Reset while in WAIT.
    drive_instr(`EXE_LW_OP, 32'h4000, 32'h0);
    #1;
    bus.addr_ok = 1'b1;
    @(negedge clk);
    bus.addr_ok = 1'b0;
    #1;
    check("wait req", {31'd0, bus.req}, 32'd0);
    check("wait stall", {31'd0, stall}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid reset req", {31'd0, bus.req}, 32'd0);
    check("mid reset stall", {31'd0, stall}, 32'd0);
    check("mid reset result", result, 32'h4000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post reset req", {31'd0, bus.req}, 32'd1);
    check("post reset stall", {31'd0, stall}, 32'd1);
    bus.addr_ok = 1'b1;
    @(negedge clk);
    bus.addr_ok = 1'b0;
    #1;
    bus.data_ok = 1'b1;
    bus.rdata   = 32'h0BADF00D;
    @(negedge clk);
    bus.data_ok = 1'b0;
    #1;
    check("post reset stall done", {31'd0, stall}, 32'd0);
    check("post reset result", result, 32'h0BADF00D);
    @(negedge clk);
    drive_nop();
    @(negedge clk);

    // Misaligned word load and store.
    drive_instr(`EXE_LW_OP, 32'h1002, 32'h0);
    #1;
`ifdef MEM_ADDR_EXC_EN
    check("misal exc_load", {31'd0, exc_l}, 32'd1);
    check("misal exc_store", {31'd0, exc_s}, 32'd0);
    check("misal bad_vaddr", bva, 32'h1002);
    check("misal req", {31'd0, bus.req}, 32'd0);
    check("misal stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    drive_instr(`EXE_SW_OP, 32'h2001, 32'h5);
    #1;
    check("misal st exc_store", {31'd0, exc_s}, 32'd1);
    check("misal st exc_load", {31'd0, exc_l}, 32'd0);
    check("misal st bad_vaddr", bva, 32'h2001);
    check("misal st req", {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    drive_nop();
    @(negedge clk);
`else
    check("misal exc_load", {31'd0, exc_l}, 32'd0);
    check("misal bad_vaddr", bva, 32'd0);
    check("misal req", {31'd0, bus.req}, 32'd1);
    @(negedge clk);
    run_txn("misal lw", `EXE_LW_OP, 32'h1002, 32'h0, 32'hCAFE1234, 0, 1, 32'hCAFE1234, 2'd2, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
